// File: rtl/board_input_conditioner.sv
// Board input conditioner: synchronised, debounced buttons plus a lock-qualified
// system reset sequencer. Define BOARD_INPUT_EVENT_EN for press/release pulses.
module board_input_conditioner #(
  parameter int N_BTN           = 2,
  parameter int DEBOUNCE_CYCLES = 240000,
  parameter int RST_HOLD_CYCLES = 1024,
  parameter int CNT_W           = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_i,
  input  logic             locked_i,
  output logic [N_BTN-1:0] btn_o,
  output logic [N_BTN-1:0] press_o,
  output logic [N_BTN-1:0] release_o,
  output logic             sys_rst_n_o
);

  localparam logic [CNT_W-1:0] DB_LAST =
    CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST =
    CNT_W'(RST_HOLD_CYCLES - 1);

  typedef enum logic {
    HOLD,
    RUN
  } state_t;

  logic [N_BTN-1:0] btn_s1;
  logic [N_BTN-1:0] btn_s2;
  logic             lock_s1;
  logic             lock_s2;

  logic [N_BTN-1:0][CNT_W-1:0] db_cnt;
  logic [N_BTN-1:0]            hit;

  state_t           state;
  state_t           state_d;
  logic [CNT_W-1:0] hold_cnt;
  logic             sys_rst_n_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_s1  <= '0;
      btn_s2  <= '0;
      lock_s1 <= 1'b0;
      lock_s2 <= 1'b0;
    end else begin
      btn_s1  <= btn_i;
      btn_s2  <= btn_s1;
      lock_s1 <= locked_i;
      lock_s2 <= lock_s1;
    end
  end

  // A button is accepted once it has differed for DEBOUNCE_CYCLES cycles.
  always_comb begin
    hit = '0;
    for (int i = 0; i < N_BTN; i++) begin
      hit[i] = (btn_s2[i] != btn_o[i]) &&
               (db_cnt[i] == DB_LAST);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      db_cnt <= '0;
    end else begin
      for (int i = 0; i < N_BTN; i++) begin
        if (btn_s2[i] == btn_o[i] || hit[i])
          db_cnt[i] <= '0;
        else
          db_cnt[i] <= db_cnt[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      btn_o <= '0;
    else
      btn_o <= btn_o ^ hit;
  end

`ifdef BOARD_INPUT_EVENT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      press_o   <= '0;
      release_o <= '0;
    end else begin
      press_o   <= hit & btn_s2;
      release_o <= hit & ~btn_s2;
    end
  end
`else
  assign press_o   = '0;
  assign release_o = '0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= HOLD;
      sys_rst_n_o <= 1'b0;
    end else begin
      state       <= state_d;
      sys_rst_n_o <= sys_rst_n_d;
    end
  end

  always_comb begin
    state_d = state;
    unique case (state)
      HOLD:
        if (lock_s2 && hold_cnt == HOLD_LAST)
          state_d = RUN;
      RUN:
        if (!lock_s2)
          state_d = HOLD;
      default:
        state_d = HOLD;
    endcase
  end

  // Registered so the downstream reset never sees a comb glitch.
  always_comb begin
    sys_rst_n_d = (state_d == RUN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      hold_cnt <= '0;
    else if (state != HOLD || !lock_s2 ||
             hold_cnt == HOLD_LAST)
      hold_cnt <= '0;
    else
      hold_cnt <= hold_cnt + 1'b1;
  end

endmodule

// File: doc/board_input_conditioner.md
BOARD_INPUT_CONDITIONER -- requirements
Module: board_input_conditioner

Interface
REQ-001 SHALL have parameter N_BTN, default 2: number of push-button inputs conditioned (1..8).
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 240000: stable cycles required to accept a button change (20 ms at 12 MHz); legal range 2..2^CNT_W-1.
REQ-003 SHALL have parameter RST_HOLD_CYCLES, default 1024: cycles system reset is held after lock qualifies; legal range 2..2^CNT_W-1.
REQ-004 SHALL have parameter CNT_W, default 20: width of the debounce and hold counters.
REQ-005 SHALL have port clk, input, 1: the single clock; all logic is on its rising edge.
REQ-006 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-007 SHALL have port btn_i, input, N_BTN: raw asynchronous board buttons, active-high.
REQ-008 SHALL have port locked_i, input, 1: asynchronous clock-generator lock status.
REQ-009 SHALL have port btn_o, output, N_BTN: debounced button levels.
REQ-010 SHALL have port press_o, output, N_BTN: one-cycle pulse per accepted 0->1 change.
REQ-011 SHALL have port release_o, output, N_BTN: one-cycle pulse per accepted 1->0 change.
REQ-012 SHALL have port sys_rst_n_o, output, 1: active-low system reset for the downstream core.

Function
REQ-013 SHALL pass each btn_i bit and locked_i through a dedicated 2-flop synchroniser before any use.
REQ-014 SHALL keep one CNT_W-bit counter per button; counter clears whenever the synchronised bit equals btn_o, else increments.
REQ-015 SHALL, when the counter equals DEBOUNCE_CYCLES-1 and the synchronised bit still differs, update btn_o to it and clear the counter in the same edge.
REQ-016 SHALL accept a clean step on btn_i at btn_o exactly 2+DEBOUNCE_CYCLES cycles after the first sampling edge.
REQ-017 SHALL reject any glitch shorter than DEBOUNCE_CYCLES synchronised cycles: btn_o and pulses unchanged, counter restarts at 0 on every bounce.
REQ-018 SHALL assert press_o[i] or release_o[i] for exactly one cycle, coincident with the btn_o[i] update; never both in one cycle.
REQ-019 SHALL handle all buttons independently; simultaneous changes on several bits yield simultaneous pulses.
REQ-020 SHALL implement a reset sequencer FSM with states HOLD and RUN and a CNT_W-bit hold counter.
REQ-021 SHALL, in HOLD, drive sys_rst_n_o low; increment the hold counter while synchronised lock is 1, clear it while 0.
REQ-022 SHALL transition HOLD->RUN when the hold counter equals RST_HOLD_CYCLES-1 with lock 1; sys_rst_n_o goes high on that edge.
REQ-023 SHALL, in RUN, drive sys_rst_n_o high; on synchronised lock 0 go to HOLD, clear the hold counter, sys_rst_n_o low on that edge.
REQ-024 SHALL drive sys_rst_n_o directly from a register (glitch-free, no combinational path).
REQ-025 SHALL never allow either counter to wrap; counters never exceed their terminal value.

Reset
REQ-026 SHALL, while rst is high, force immediately: synchronisers 0, counters 0, btn_o 0, press_o 0, release_o 0, FSM HOLD, sys_rst_n_o 0.
REQ-027 SHALL, on rst asserted mid-debounce or mid-hold, abandon the operation; no pulse is emitted.
REQ-028 SHALL, after rst release with buttons held high, report the press through the normal path (press_o pulses once).

Configuration
REQ-029 SHALL support macro BOARD_INPUT_EVENT_EN: when defined, press_o/release_o behave per REQ-018.
REQ-030 SHALL, when BOARD_INPUT_EVENT_EN is undefined, tie press_o and release_o to 0 with no event logic; btn_o and sys_rst_n_o are unchanged.

Verification (DEBOUNCE_CYCLES=4, RST_HOLD_CYCLES=8, N_BTN=2)
REQ-031 SHALL check: rst high, locked_i=1 from cycle 0, rst released at cycle 0 -> sys_rst_n_o rises exactly 2+8 cycles later.
REQ-032 SHALL check: btn_i[0] 0->1 clean step -> btn_o[0]=1 and press_o[0]=1 for one cycle at edge 6; btn_o[1] stays 0.
REQ-033 SHALL check: btn_i[1] pulses high for 3 cycles, repeated every 5 cycles -> btn_o[1] stays 0, no pulses.
REQ-034 SHALL check: locked_i drops for 1 cycle in RUN -> sys_rst_n_o low 2 cycles later, high again 8 cycles after lock resynchronises.
REQ-035 SHALL check: both buttons released together after being debounced high -> release_o=2'b11 for one cycle, btn_o=2'b00.
REQ-036 SHALL check: rst pulsed mid-debounce (counter=2) -> all outputs 0 at once; no press_o until a full 2+4 cycles after release.
